// File: rtl/uart_pkg.sv
// Shared debug-transport definitions: address map, payload widths and
// types used by the TAP read/write interconnects.
package uart_pkg;

   localparam int IRLENGTH  = 5;
   localparam int DMI_WIDTH = 41;
   localparam int TRB_WIDTH = 32;

   localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h04;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h05;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h06;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h07;
   localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;

   // device slot indices of the one-hot select vector
   localparam int NDEV     = 5;
   localparam int DEV_DMI  = 0;
   localparam int DEV_S0CS = 1;
   localparam int DEV_S0D  = 2;
   localparam int DEV_S1CS = 3;
   localparam int DEV_S1D  = 4;

   typedef struct packed {
      logic [5:0] rsvd;
      logic       stop;
      logic       start;
   } control_t;

   typedef enum logic {
      WR_IDLE,
      WR_SEND
   } wr_state_t;

endpackage

// File: rtl/tap_write_interconnect.sv
// Single-entry write buffer routing one TAP write word to DMI/STB peripherals.
// Ports: TAP write handshake + done/error pulses; one valid/ready/data per device.
module tap_write_interconnect
   import uart_pkg::*;
#(
   parameter int WRITE_WIDTH = 41,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   CLK_I,
   input  logic                   RST_NI,
   input  logic [IRLENGTH-1:0]    WRITE_ADDRESS_I,
   input  logic [WRITE_WIDTH-1:0] WRITE_DATA_I,
   input  logic                   WRITE_VALID_I,
   output logic                   WRITE_READY_O,
   output logic                   WRITE_DONE_O,
   output logic                   WRITE_ERROR_O,
   output logic                   DMI_WRITE_VALID_O,
   input  logic                   DMI_WRITE_READY_I,
   output logic [DMI_WIDTH-1:0]   DMI_WRITE_DATA_O,
   output logic                   STB0_CONTROL_VALID_O,
   input  logic                   STB0_CONTROL_READY_I,
   output control_t               STB0_CONTROL_O,
   output logic                   STB0_DATA_VALID_O,
   input  logic                   STB0_DATA_READY_I,
   output logic [TRB_WIDTH-1:0]   STB0_DATA_O,
   output logic                   STB1_CONTROL_VALID_O,
   input  logic                   STB1_CONTROL_READY_I,
   output control_t               STB1_CONTROL_O,
   output logic                   STB1_DATA_VALID_O,
   input  logic                   STB1_DATA_READY_I,
   output logic [TRB_WIDTH-1:0]   STB1_DATA_O
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CTW = $bits(control_t);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   // one-hot device select; zero for unmapped or read-only addresses
   function automatic logic [NDEV-1:0] decode(input logic [IRLENGTH-1:0] a);
      logic [NDEV-1:0] s;
      s = '0;
      case (a)
         ADDR_DMI:     s[DEV_DMI]  = 1'b1;
         ADDR_STB0_CS: s[DEV_S0CS] = 1'b1;
         ADDR_STB0_D:  s[DEV_S0D]  = 1'b1;
         ADDR_STB1_CS: s[DEV_S1CS] = 1'b1;
         ADDR_STB1_D:  s[DEV_S1D]  = 1'b1;
         default:      s = '0;
      endcase
      return s;
   endfunction

   wr_state_t             state_q, state_d;
   logic [IRLENGTH-1:0]   addr_q;
   logic [CW-1:0]         cnt_q;
   logic                  ready_q, done_q, error_q;
   logic [DMI_WIDTH-1:0]  dmi_q;
   control_t              s0c_q, s1c_q;
   logic [TRB_WIDTH-1:0]  s0d_q, s1d_q;

   logic [NDEV-1:0] in_sel, sel_q, dev_rdy, valid;
   logic            accept, mapped, send, hs, tmo;

   assign in_sel  = decode(WRITE_ADDRESS_I);
   assign sel_q   = decode(addr_q);
   assign mapped  = |in_sel;
   assign accept  = WRITE_VALID_I & ready_q;
   assign send    = (state_q == WR_SEND);
   assign dev_rdy = {STB1_DATA_READY_I, STB1_CONTROL_READY_I,
                     STB0_DATA_READY_I, STB0_CONTROL_READY_I,
                     DMI_WRITE_READY_I};
   assign hs      = send & |(sel_q & dev_rdy);
   assign tmo     = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) state_q <= WR_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WR_IDLE: if (accept && mapped) state_d = WR_SEND;
         WR_SEND: if (hs || tmo)        state_d = WR_IDLE;
         default: state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      valid = '0;
      if (send) valid = sel_q;
   end

   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         dmi_q   <= '0;
         s0c_q   <= '0;
         s0d_q   <= '0;
         s1c_q   <= '0;
         s1d_q   <= '0;
      end else begin
         ready_q <= (state_d == WR_IDLE);
         done_q  <= hs;
         error_q <= (accept & ~mapped) | (send & ~hs & tmo);
         if (accept && mapped) begin
            addr_q <= WRITE_ADDRESS_I;
            cnt_q  <= '0;
            // device registers double as the data holding buffer
            if (in_sel[DEV_DMI])  dmi_q <= WRITE_DATA_I[DMI_WIDTH-1:0];
            if (in_sel[DEV_S0CS]) s0c_q <= control_t'(WRITE_DATA_I[CTW-1:0]);
            if (in_sel[DEV_S0D])  s0d_q <= WRITE_DATA_I[TRB_WIDTH-1:0];
            if (in_sel[DEV_S1CS]) s1c_q <= control_t'(WRITE_DATA_I[CTW-1:0]);
            if (in_sel[DEV_S1D])  s1d_q <= WRITE_DATA_I[TRB_WIDTH-1:0];
         end else if (send && !hs) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign WRITE_READY_O        = ready_q;
   assign WRITE_DONE_O         = done_q;
   assign WRITE_ERROR_O        = error_q;
   assign DMI_WRITE_VALID_O    = valid[DEV_DMI];
   assign STB0_CONTROL_VALID_O = valid[DEV_S0CS];
   assign STB0_DATA_VALID_O    = valid[DEV_S0D];
   assign STB1_CONTROL_VALID_O = valid[DEV_S1CS];
   assign STB1_DATA_VALID_O    = valid[DEV_S1D];
   assign DMI_WRITE_DATA_O     = dmi_q;
   assign STB0_CONTROL_O       = s0c_q;
   assign STB0_DATA_O          = s0d_q;
   assign STB1_CONTROL_O       = s1c_q;
   assign STB1_DATA_O          = s1d_q;

endmodule
